// File: rtl/issue_scheduler.sv
// issue_scheduler: per-cycle reservation-station select logic.
// Scans RS entries round-robin from rr_ptr, granting eligible entries subject
// to per-class caps and to a common-data-bus budget. Pipelined multiplier
// results are tracked by a shift register of future broadcast counts (R).
module issue_scheduler #(
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned WAY      = 3,
  parameter int unsigned NUM_ALU  = 3,
  parameter int unsigned NUM_MULT = 2,
  parameter int unsigned MULT_LAT = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [RS_SIZE-1:0]               entry_valid,
  input  logic [RS_SIZE-1:0]               entry_ready,
  input  logic [RS_SIZE-1:0][1:0]          entry_fu_type,
  input  logic                             mem_ready,
  input  logic                             squash,
  output logic [RS_SIZE-1:0]               issue_grant,
  output logic [$clog2(RS_SIZE+1)-1:0]     alu_cnt,
  output logic [$clog2(RS_SIZE+1)-1:0]     mult_cnt,
  output logic                             mem_issue,
  output logic                             br_issue,
  output logic [$clog2(WAY+1)-1:0]         mult_wb_next
);

  localparam int unsigned PTR_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(RS_SIZE + 1);
  localparam int unsigned WB_W  = $clog2(WAY + 1);
  localparam int unsigned RSLOT = MULT_LAT - 1;
  localparam int unsigned R_W   = RSLOT * CNT_W;

  localparam logic [1:0] FU_ALU  = 2'd0;
  localparam logic [1:0] FU_MULT = 2'd1;
  localparam logic [1:0] FU_MEM  = 2'd2;
  localparam logic [1:0] FU_BR   = 2'd3;

  // rr_q: scan start; r_q[j] (j=1..MULT_LAT-1): mult results broadcasting in j cycles
  logic [PTR_W-1:0]            rr_q, rr_d;
  logic [RSLOT:1][CNT_W-1:0]   r_q, r_d;

  logic [RS_SIZE-1:0]          grant_c;
  logic [CNT_W-1:0]            alu_c, mult_c;
  logic                        mem_c, br_c;

  // Round-robin scan with per-class caps and the shared CDB budget for ALU/BRANCH
  always_comb begin : scan_p
    int unsigned      alu_left;
    int unsigned      mult_left;
    int unsigned      mem_left;
    int unsigned      br_left;
    int unsigned      cdb_left;
    logic [PTR_W-1:0] idx;
    logic             take;
    grant_c   = '0;
    alu_c     = '0;
    mult_c    = '0;
    mem_c     = 1'b0;
    br_c      = 1'b0;
    rr_d      = rr_q;
    alu_left  = NUM_ALU;
    mult_left = NUM_MULT;
    mem_left  = mem_ready ? 32'd1 : 32'd0;
    br_left   = 32'd1;
    cdb_left  = (WAY > 32'(r_q[1])) ? (WAY - 32'(r_q[1])) : 32'd0;
    idx       = '0;
    take      = 1'b0;
    for (int unsigned k = 0; k < RS_SIZE; k++) begin
      idx  = PTR_W'((32'(rr_q) + k) % RS_SIZE);
      take = 1'b0;
      if (!reset && !squash && entry_valid[idx] && entry_ready[idx]) begin
        case (entry_fu_type[idx])
          FU_ALU: begin
            if (alu_left != 0 && cdb_left != 0) begin
              take     = 1'b1;
              alu_left = alu_left - 1;
              cdb_left = cdb_left - 1;
              alu_c    = alu_c + CNT_W'(1);
            end
          end
          FU_MULT: begin
            if (mult_left != 0) begin
              take      = 1'b1;
              mult_left = mult_left - 1;
              mult_c    = mult_c + CNT_W'(1);
            end
          end
          FU_MEM: begin
            if (mem_left != 0) begin
              take     = 1'b1;
              mem_left = 32'd0;
              mem_c    = 1'b1;
            end
          end
          FU_BR: begin
            if (br_left != 0 && cdb_left != 0) begin
              take     = 1'b1;
              br_left  = 32'd0;
              cdb_left = cdb_left - 1;
              br_c     = 1'b1;
            end
          end
          default: take = 1'b0;
        endcase
      end
      if (take) begin
        grant_c[idx] = 1'b1;
        rr_d         = PTR_W'((32'(idx) + 1) % RS_SIZE);
      end
    end
  end

  // Advance the broadcast reservation pipe; this cycle's mult grants enter at the far end
  always_comb begin
    r_d = R_W'({mult_c, r_q} >> CNT_W);
  end

  // State registers: squash clears the pipe and restarts the scan at entry 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q <= '0;
      r_q  <= '0;
    end else if (squash) begin
      rr_q <= '0;
      r_q  <= '0;
    end else begin
      rr_q <= rr_d;
      r_q  <= r_d;
    end
  end

  assign issue_grant  = grant_c;
  assign alu_cnt      = alu_c;
  assign mult_cnt     = mult_c;
  assign mem_issue    = mem_c;
  assign br_issue     = br_c;
  assign mult_wb_next = WB_W'(r_q[1]);

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter RS_SIZE, default 16, number of reservation-station entries scanned.
REQ-002 Parameter WAY, default 3, CDB broadcast slots per cycle.
REQ-003 Parameter NUM_ALU, default 3, ALU issues per cycle.
REQ-004 Parameter NUM_MULT, default 2, pipelined multiplier issues per cycle.
REQ-005 Parameter MULT_LAT, default 4, multiplier latency in cycles; legal range is 2 or more.
REQ-006 Port list, clock and reset first, in the order below.
REQ-007 clock  in  1  sole clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 entry_valid  in  RS_SIZE  RS entry occupied.
REQ-010 entry_ready  in  RS_SIZE  both source operands available.
REQ-011 entry_fu_type  in  RS_SIZE x 2  class per entry: 0 ALU, 1 MULT, 2 MEM, 3 BRANCH.
REQ-012 mem_ready  in  1  memory unit accepts one request this cycle.
REQ-013 squash  in  1  branch-mispredict flush.
REQ-014 issue_grant  out  RS_SIZE  entries issued this cycle (combinational).
REQ-015 alu_cnt, mult_cnt  out  clog2(RS_SIZE+1) each  ALU and MULT grants this cycle.
REQ-016 mem_issue, br_issue  out  1 each  MEM and BRANCH granted this cycle.
REQ-017 mult_wb_next  out  clog2(WAY+1)  multiplier results broadcasting next cycle (R[1]).

Function
REQ-018 Eligible entry: entry_valid=1 and entry_ready=1.
REQ-019 Scan order: from rr_ptr ascending, wrapping modulo RS_SIZE; each entry is visited once per cycle.
REQ-020 Caps: ALU grants <= NUM_ALU; MULT grants <= NUM_MULT; MEM grants <= 1 and only when mem_ready=1; BRANCH grants <= 1.
REQ-021 ALU and BRANCH have latency 1; their combined grants <= WAY - R[1].
REQ-022 MULT grants are limited only by NUM_MULT.
REQ-023 MEM grants do not consume a CDB reservation; the LSQ arbitrates its own writeback.
REQ-024 Each eligible entry is granted in scan order unless its class cap or budget is exhausted; a skipped entry does not block later entries.
REQ-025 Reservation register R[1..MULT_LAT-1]: R[j] is the number of multiplier results broadcasting j cycles ahead.
REQ-026 Each clock: R[j] <= R[j+1] for j < MULT_LAT-1, and R[MULT_LAT-1] <= mult_cnt.
REQ-027 rr_ptr update: after any grant, rr_ptr <= (last granted index in scan order + 1) mod RS_SIZE; with no grant, rr_ptr holds.
REQ-028 In a squash=1 cycle: all grants and counts are 0; R is cleared to 0 and rr_ptr is set to 0 at the next edge.
REQ-029 Counts equal the popcount of issue_grant per class; mem_issue and br_issue equal the OR of the matching grants.
REQ-030 Total grants in a cycle are at most NUM_ALU+NUM_MULT+2; issue_grant is a subset of eligible entries.

Reset
REQ-031 While reset=1: rr_ptr=0, all R[j]=0, and every output is 0, independent of clock.
REQ-032 After reset deasserts, the first clock edge starts scanning from entry 0.

Verification
REQ-033 Reset asserted mid-operation with R nonzero -> outputs 0 immediately; R=0 and rr_ptr=0 after release.
REQ-034 Entries 0-4 ALU eligible, rr_ptr=0 -> grant 0,1,2, alu_cnt=3, rr_ptr=3; next cycle with 3-4 eligible -> grant 3,4, rr_ptr=5.
REQ-035 Cycle t: entries 0,1 MULT eligible -> mult_cnt=2; cycle t+3: mult_wb_next=2 and only 1 of 4 eligible ALU entries granted.
REQ-036 Entries 2,3 MEM eligible, mem_ready=1 -> only entry 2 granted; mem_ready=0 -> no MEM grant.
REQ-037 rr_ptr=14, entries 15 and 0 ALU eligible -> both granted, rr_ptr=1.
REQ-038 squash=1 with R[2]=2 and eligible entries present -> issue_grant=0; next cycle R all 0 and rr_ptr=0.
